// File: rtl/ili9341_bus_receiver_if.sv
// Bus bundle for the ILI9341 receiver: 8080 write-side pins from the host
// plus the AXI-Stream pixel output toward the downstream consumer.
interface ili9341_bus_receiver_if;
   logic [7:0]  data;
   logic        rd;
   logic        wr;
   logic        cs;
   logic        dc;
   logic        rst;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [15:0] m_axis_tdata;

   // Host side: drives the display bus and accepts pixels.
   modport master (
      output data, rd, wr, cs, dc, rst, m_axis_tready,
      input  m_axis_tvalid, m_axis_tlast, m_axis_tdata
   );

   // Receiver side: samples the display bus and produces pixels.
   modport slave (
      input  data, rd, wr, cs, dc, rst, m_axis_tready,
      output m_axis_tvalid, m_axis_tlast, m_axis_tdata
   );
endinterface

// File: rtl/ili9341_bus_receiver.sv
// ILI9341 8080-bus responder: synchronizes the host pins, decodes the
// command stream (CASET/PASET/MADCTL/SWRESET/MEMWR) and streams RGB565
// pixels through a small FIFO onto AXI-Stream with tlast at window end.
module ili9341_bus_receiver #(
   parameter int X_RES       = 320,
   parameter int Y_RES       = 240,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   aclk,
   input  logic                   resetn,
   ili9341_bus_receiver_if.slave  bus,
   output logic [7:0]             madctl,
   output logic                   overflow
);

   localparam int              AW     = $clog2(FIFO_DEPTH);
   localparam logic [15:0]     EC_DEF = 16'(X_RES - 1);
   localparam logic [15:0]     EP_DEF = 16'(Y_RES - 1);
   localparam logic [AW:0]     DEPTH  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CASET, ST_PASET, ST_MADCTL, ST_MEMWR, ST_IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] wr_sync, cs_sync, rst_sync, dc_sync;
   logic [7:0]             data_sync [SYNC_STAGES];
   logic                   wr_prev;
   logic                   wr_s, cs_s, rst_s, dc_s;
   logic [7:0]             byte_s;

   state_t      state;
   logic [1:0]  param_cnt;
   logic [23:0] param_buf;
   logic [15:0] sc, ec, sp, ep;
   logic [15:0] win_w, win_h, col, row;
   logic        phase;
   logic [7:0]  high_byte;

   logic [16:0] mem [FIFO_DEPTH];
   logic [AW:0] wptr, rptr, count;
   logic        strobe, soft_rst, push_req, last_pix, full, pop;

   // Shift every bus pin through the synchronizer chain; idle bus after reset.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         wr_sync  <= '1;
         cs_sync  <= '1;
         rst_sync <= '1;
         dc_sync  <= '0;
         wr_prev  <= 1'b1;
         for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
      end else begin
         wr_sync  <= {wr_sync[SYNC_STAGES-2:0], bus.wr};
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
         rst_sync <= {rst_sync[SYNC_STAGES-2:0], bus.rst};
         dc_sync  <= {dc_sync[SYNC_STAGES-2:0], bus.dc};
         wr_prev  <= wr_sync[SYNC_STAGES-1];
         data_sync[0] <= bus.data;
         for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      end
   end

   // Strobe detection and the per-byte pixel push decision.
   always_comb begin
      wr_s     = wr_sync[SYNC_STAGES-1];
      cs_s     = cs_sync[SYNC_STAGES-1];
      rst_s    = rst_sync[SYNC_STAGES-1];
      dc_s     = dc_sync[SYNC_STAGES-1];
      byte_s   = data_sync[SYNC_STAGES-1];
      strobe   = wr_s && !wr_prev && !cs_s;
      soft_rst = !rst_s;
      push_req = strobe && dc_s && phase && (state == ST_MEMWR) && !soft_rst;
      last_pix = (col == win_w - 16'd1) && (row == win_h - 16'd1);
      count    = wptr - rptr;
      full     = (count == DEPTH);
      pop      = (count != '0) && bus.m_axis_tready;
   end

   // Command decoder: window/madctl registers, parameter collection and pixel counters.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         param_cnt <= '0;
         param_buf <= '0;
         sc        <= '0;
         ec        <= EC_DEF;
         sp        <= '0;
         ep        <= EP_DEF;
         madctl    <= '0;
         win_w     <= 16'(X_RES);
         win_h     <= 16'(Y_RES);
         col       <= '0;
         row       <= '0;
         phase     <= 1'b0;
         high_byte <= '0;
      end else if (soft_rst) begin
         state     <= ST_IDLE;
         param_cnt <= '0;
         sc        <= '0;
         ec        <= EC_DEF;
         sp        <= '0;
         ep        <= EP_DEF;
         madctl    <= '0;
         phase     <= 1'b0;
      end else if (cs_s) begin
         state     <= ST_IDLE;
         param_cnt <= '0;
         phase     <= 1'b0;
      end else if (strobe) begin
         if (!dc_s) begin
            param_cnt <= '0;
            phase     <= 1'b0;
            case (byte_s)
               8'h2A: state <= ST_CASET;
               8'h2B: state <= ST_PASET;
               8'h36: state <= ST_MADCTL;
               8'h01: begin
                  state  <= ST_IDLE;
                  sc     <= '0;
                  ec     <= EC_DEF;
                  sp     <= '0;
                  ep     <= EP_DEF;
                  madctl <= '0;
               end
               8'h2C: begin
                  state <= ST_MEMWR;
                  col   <= '0;
                  row   <= '0;
                  win_w <= (ec >= sc) ? (ec - sc + 16'd1) : 16'd1;
                  win_h <= (ep >= sp) ? (ep - sp + 16'd1) : 16'd1;
               end
               default: state <= ST_IGNORE;
            endcase
         end else begin
            case (state)
               ST_CASET, ST_PASET: begin
                  if (param_cnt == 2'd3) begin
                     if (state == ST_CASET) begin
                        sc <= param_buf[23:8];
                        ec <= {param_buf[7:0], byte_s};
                     end else begin
                        sp <= param_buf[23:8];
                        ep <= {param_buf[7:0], byte_s};
                     end
                     param_cnt <= '0;
                     state     <= ST_IDLE;
                  end else begin
                     param_buf <= {param_buf[15:0], byte_s};
                     param_cnt <= param_cnt + 2'd1;
                  end
               end
               ST_MADCTL: begin
                  madctl <= byte_s;
                  state  <= ST_IDLE;
               end
               ST_MEMWR: begin
                  if (!phase) begin
                     high_byte <= byte_s;
                     phase     <= 1'b1;
                  end else begin
                     phase <= 1'b0;
                     if (col == win_w - 16'd1) begin
                        col <= '0;
                        row <= (row == win_h - 16'd1) ? 16'd0 : row + 16'd1;
                     end else begin
                        col <= col + 16'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Pixel FIFO with sticky overflow; fullness uses the count before any pop.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (soft_rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_req) begin
            if (full) begin
               overflow <= 1'b1;
            end else begin
               mem[wptr[AW-1:0]] <= {last_pix, high_byte, byte_s};
               wptr <= wptr + 1'b1;
            end
         end
         if (pop) rptr <= rptr + 1'b1;
      end
   end

   assign bus.m_axis_tvalid = (count != '0);
   assign bus.m_axis_tdata  = mem[rptr[AW-1:0]][15:0];
   assign bus.m_axis_tlast  = mem[rptr[AW-1:0]][16];

endmodule

// File: tb/tb_ili9341_bus_receiver.sv
// Bench for ili9341_bus_receiver: drives directed 8080 write sequences and
// checks streamed pixels against a queue of hand-computed expected beats.
module tb_ili9341_bus_receiver;

   logic       aclk;
   logic       resetn;
   logic [7:0] madctl;
   logic       overflow;
   int         check_count;
   int         pass_count;
   logic [16:0] exp_q [$];

   ili9341_bus_receiver_if bus ();

   ili9341_bus_receiver dut (
      .aclk     (aclk),
      .resetn   (resetn),
      .bus      (bus),
      .madctl   (madctl),
      .overflow (overflow)
   );

   // Free-running 100 MHz clock.
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Hard stop in case the run never reaches its summary.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Monitor: every accepted beat is compared with the oldest expected pixel.
   always @(negedge aclk) begin
      if (resetn && bus.m_axis_tvalid && bus.m_axis_tready) begin
         if (exp_q.size() == 0) begin
            check_count++;
            $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no beat",
                     {bus.m_axis_tlast, bus.m_axis_tdata});
         end else begin
            check_output("beat", {15'd0, bus.m_axis_tlast, bus.m_axis_tdata}, {15'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic send_byte(input logic is_data, input logic [7:0] value);
      bus.dc   = is_data;
      bus.data = value;
      bus.wr   = 1'b0;
      tick(2);
      bus.wr   = 1'b1;
      tick(3);
   endtask

   task automatic cmd(input logic [7:0] value);
      send_byte(1'b0, value);
   endtask

   task automatic par(input logic [7:0] value);
      send_byte(1'b1, value);
   endtask

   task automatic par4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
      par(a); par(b); par(c); par(d);
   endtask

   task automatic send_pixel(input logic [15:0] pix, input logic expect_last, input logic keep);
      if (keep) exp_q.push_back({expect_last, pix});
      par(pix[15:8]);
      par(pix[7:0]);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
      tick(3);
      check_output("drain_empty", exp_q.size(), 0);
   endtask

   // Directed scenarios; expected beats are queued as each pixel is sent.
   initial begin
      check_count = 0;
      pass_count  = 0;
      resetn = 1'b0;
      bus.data = 8'h00; bus.rd = 1'b1; bus.wr = 1'b1; bus.cs = 1'b1;
      bus.dc = 1'b0; bus.rst = 1'b1; bus.m_axis_tready = 1'b1;
      tick(3);
      check_output("rst_tvalid", bus.m_axis_tvalid, 0);
      check_output("rst_tlast", bus.m_axis_tlast, 0);
      check_output("rst_tdata", bus.m_axis_tdata, 0);
      check_output("rst_madctl", madctl, 0);
      check_output("rst_overflow", overflow, 0);
      resetn = 1'b1;
      tick(2);
      bus.cs = 1'b0;
      tick(3);

      // Init sequence on a 4x3 window, then two pixels into the next frame.
      cmd(8'h01);
      cmd(8'h36); par(8'h48);
      check_output("madctl_48", madctl, 8'h48);
      cmd(8'h2A); par4(8'h00, 8'h00, 8'h00, 8'h03);
      cmd(8'h2B); par4(8'h00, 8'h00, 8'h00, 8'h02);
      cmd(8'h2C);
      for (int i = 0; i < 14; i++)
         send_pixel({8'(i), 8'(8'hA0 + i)}, (i == 11), 1'b1);
      drain();

      // W=2, H=1: tlast on beats 1 and 3.
      cmd(8'h2A); par4(8'h00, 8'h0A, 8'h00, 8'h0B);
      cmd(8'h2B); par4(8'h00, 8'h05, 8'h00, 8'h05);
      cmd(8'h2C);
      for (int i = 0; i < 4; i++) send_pixel(16'h1100 + 16'(i), (i % 2 == 1), 1'b1);
      drain();

      // end < start gives W=1; default H=240 means no tlast, then H=3 shows tlast on beat 2.
      cmd(8'h01);
      cmd(8'h2A); par4(8'h00, 8'h05, 8'h00, 8'h03);
      cmd(8'h2C);
      for (int i = 0; i < 3; i++) send_pixel(16'h2200 + 16'(i), 1'b0, 1'b1);
      cmd(8'h2B); par4(8'h00, 8'h00, 8'h00, 8'h02);
      cmd(8'h2C);
      for (int i = 0; i < 3; i++) send_pixel(16'h3300 + 16'(i), (i == 2), 1'b1);
      drain();

      // Partial CASET discarded by cs high; trailing bytes must not complete it.
      cmd(8'h01);
      cmd(8'h2A); par(8'h00); par(8'h00);
      bus.cs = 1'b1; tick(4); bus.cs = 1'b0; tick(3);
      par(8'h00); par(8'h03);
      cmd(8'h2B); par4(8'h00, 8'h00, 8'h00, 8'h00);
      cmd(8'h2C);
      for (int i = 0; i < 4; i++) send_pixel(16'h4400 + 16'(i), 1'b0, 1'b1);
      par(8'hEE);
      cmd(8'h29);
      par(8'h77);
      cmd(8'h2C);
      send_pixel(16'h1234, 1'b0, 1'b1);
      drain();
      check_output("madctl_after_swreset", madctl, 0);

      // Overflow: FIFO_DEPTH+1 pixels with tready low, only the first four survive.
      bus.m_axis_tready = 1'b0;
      cmd(8'h2A); par4(8'h00, 8'h00, 8'h00, 8'h00);
      cmd(8'h2B); par4(8'h00, 8'h00, 8'h00, 8'h04);
      cmd(8'h2C);
      for (int i = 0; i < 5; i++) send_pixel(16'h5500 + 16'(i), (i == 4), (i < 4));
      tick(3);
      check_output("overflow_set", overflow, 1);
      check_output("tvalid_held", bus.m_axis_tvalid, 1);
      bus.m_axis_tready = 1'b1;
      drain();
      check_output("tvalid_after_drain", bus.m_axis_tvalid, 0);

      // Bus rst mid-MEMWR flushes FIFO and restores window/madctl; overflow sticks.
      cmd(8'h2A); par4(8'h00, 8'h00, 8'h00, 8'h00);
      cmd(8'h2B); par4(8'h00, 8'h00, 8'h00, 8'h00);
      cmd(8'h36); par(8'h5A);
      bus.m_axis_tready = 1'b0;
      cmd(8'h2C);
      send_pixel(16'h6600, 1'b1, 1'b0);
      send_pixel(16'h6601, 1'b1, 1'b0);
      tick(2);
      check_output("tvalid_before_busrst", bus.m_axis_tvalid, 1);
      bus.rst = 1'b0; tick(4); bus.rst = 1'b1; tick(4);
      check_output("busrst_tvalid", bus.m_axis_tvalid, 0);
      check_output("busrst_madctl", madctl, 0);
      check_output("busrst_overflow_kept", overflow, 1);
      bus.m_axis_tready = 1'b1;
      cmd(8'h2C);
      send_pixel(16'h7700, 1'b0, 1'b1);
      send_pixel(16'h7701, 1'b0, 1'b1);
      drain();

      // resetn mid-frame returns every output to its reset value immediately.
      cmd(8'h36); par(8'h3C);
      check_output("madctl_3c", madctl, 8'h3C);
      bus.m_axis_tready = 1'b0;
      cmd(8'h2C);
      send_pixel(16'h8800, 1'b0, 1'b0);
      send_pixel(16'h8801, 1'b0, 1'b0);
      tick(2);
      check_output("tvalid_before_resetn", bus.m_axis_tvalid, 1);
      resetn = 1'b0;
      @(negedge aclk);
      check_output("resetn_tvalid", bus.m_axis_tvalid, 0);
      check_output("resetn_tlast", bus.m_axis_tlast, 0);
      check_output("resetn_tdata", bus.m_axis_tdata, 0);
      check_output("resetn_madctl", madctl, 0);
      check_output("resetn_overflow", overflow, 0);
      tick(3);
      resetn = 1'b1;
      tick(4);
      check_output("post_reset_tvalid", bus.m_axis_tvalid, 0);
      bus.m_axis_tready = 1'b1;
      cmd(8'h2C);
      send_pixel(16'h9ABC, 1'b0, 1'b1);
      drain();

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
